// File: rtl/capture_pkg.sv
// Shared constants and debounce state encoding for the sample capture front end.
package capture_pkg;

    localparam int unsigned SAMPLE_WIDTH            = 8;
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 1_000_000;
    localparam int unsigned DEFAULT_REPEAT_CYCLES   = 50_000_000;

    typedef enum logic [1:0] {
        StIdle,
        StPressWait,
        StPressed,
        StReleaseWait
    } debounce_state_e;

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser plus debounce FSM for one active-high push-button.
// Emits a single-cycle press_pulse per accepted press; held is high while in PRESSED.
module button_debounce
    import capture_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic press_pulse,
    output logic held
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]      sync_q;
    logic            btn_s;
    debounce_state_e state_q;
    logic [CntW-1:0] cnt_q;

    assign btn_s = sync_q[1];
    assign held  = (state_q == StPressed);

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q      <= 2'b00;
            state_q     <= StIdle;
            cnt_q       <= '0;
            press_pulse <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], btn_raw};
            press_pulse <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (btn_s) begin
                        state_q <= StPressWait;
                        cnt_q   <= '0;
                    end
                end
                StPressWait: begin
                    if (!btn_s) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                    end else if (cnt_q == CntMax) begin
                        state_q     <= StPressed;
                        cnt_q       <= '0;
                        press_pulse <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StPressed: begin
                    if (!btn_s) begin
                        state_q <= StReleaseWait;
                        cnt_q   <= '0;
                    end
                end
                StReleaseWait: begin
                    // Bounce back high resumes the existing press without a new pulse.
                    if (btn_s) begin
                        state_q <= StPressed;
                        cnt_q   <= '0;
                    end else if (cnt_q == CntMax) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/sample_capture.sv
// Board input front end: synchronises switches, debounces store/next buttons and
// emits one-cycle capture/advance strobes. Optional CAPTURE_AUTOREPEAT_EN repeats next.
module sample_capture
    import capture_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [SAMPLE_WIDTH-1:0] sw_raw,
    input  logic                    btn_store_raw,
    input  logic                    btn_next_raw,
    output logic [SAMPLE_WIDTH-1:0] sample_in,
    output logic                    sample_in_valid,
    output logic                    next_sample
);

    logic [SAMPLE_WIDTH-1:0] sw_meta_q;
    logic [SAMPLE_WIDTH-1:0] sw_s_q;
    logic                    store_press;
    logic                    next_press;
    logic                    next_held;
    logic                    unused_store_held;
    logic                    repeat_pulse;

    always_ff @(posedge clk) begin
        if (reset) begin
            sw_meta_q <= '0;
            sw_s_q    <= '0;
        end else begin
            sw_meta_q <= sw_raw;
            sw_s_q    <= sw_meta_q;
        end
    end

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_store_debounce (
        .clk        (clk),
        .reset      (reset),
        .btn_raw    (btn_store_raw),
        .press_pulse(store_press),
        .held       (unused_store_held)
    );

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_next_debounce (
        .clk        (clk),
        .reset      (reset),
        .btn_raw    (btn_next_raw),
        .press_pulse(next_press),
        .held       (next_held)
    );

`ifdef CAPTURE_AUTOREPEAT_EN
    localparam int unsigned RepW = $clog2(REPEAT_CYCLES);
    localparam logic [RepW-1:0] RepMax = RepW'(REPEAT_CYCLES - 1);

    logic [RepW-1:0] rep_cnt_q;

    // Held off during the initial press pulse so the first repeat lands one full period later.
    always_ff @(posedge clk) begin
        if (reset || !next_held || next_press) begin
            rep_cnt_q <= '0;
        end else if (rep_cnt_q == RepMax) begin
            rep_cnt_q <= '0;
        end else begin
            rep_cnt_q <= rep_cnt_q + 1'b1;
        end
    end

    assign repeat_pulse = next_held && !next_press && (rep_cnt_q == RepMax);
`else
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = ^{next_held, REPEAT_CYCLES};
    assign repeat_pulse      = 1'b0;
`endif

    // Store wins a collision; the losing next event is dropped, not deferred.
    always_ff @(posedge clk) begin
        if (reset) begin
            sample_in       <= '0;
            sample_in_valid <= 1'b0;
            next_sample     <= 1'b0;
        end else begin
            sample_in_valid <= store_press;
            next_sample     <= (next_press | repeat_pulse) & ~store_press;
            if (store_press) begin
                sample_in <= sw_s_q;
            end
        end
    end

endmodule

// File: tb/tb_sample_capture.sv
// Directed and randomised bench for sample_capture against a run-length reference model.
module tb_sample_capture;

    localparam int unsigned D = 4;
    localparam int unsigned R = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] sw_raw = 8'h00;
    logic       btn_store_raw = 1'b0;
    logic       btn_next_raw = 1'b0;
    logic [7:0] sample_in;
    logic       sample_in_valid;
    logic       next_sample;

    sample_capture #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_CYCLES  (R)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .sw_raw         (sw_raw),
        .btn_store_raw  (btn_store_raw),
        .btn_next_raw   (btn_next_raw),
        .sample_in      (sample_in),
        .sample_in_valid(sample_in_valid),
        .next_sample    (next_sample)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: inputs seen by the logic are the raw values two edges old;
    // a press is accepted after D+1 consecutive high samples, a release after D+1 lows.
    logic [7:0] sw_hist[$];
    bit         btn_hist[2][$];
    bit         m_pressed[2];
    int         m_run[2];
    int         m_age[2];
    bit         acc_prev[2];
    logic       exp_valid;
    logic       exp_next;
    logic [7:0] exp_sample;

    int cyc = 0;
    int base = 0;
    int n_valid, n_next, first_valid, first_next;
    int next_idx[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        sw_hist = '{8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 2; i++) begin
            btn_hist[i] = '{1'b0, 1'b0, 1'b0};
            m_pressed[i] = 1'b0;
            m_run[i] = 0;
            m_age[i] = -1;
            acc_prev[i] = 1'b0;
        end
        exp_valid = 1'b0;
        exp_next = 1'b0;
        exp_sample = 8'h00;
    endtask

    task automatic model_edge();
        bit acc[2];
        bit b;
        if (reset) begin
            model_reset();
            return;
        end
        sw_hist.push_front(sw_raw);
        void'(sw_hist.pop_back());
        btn_hist[0].push_front(btn_store_raw);
        void'(btn_hist[0].pop_back());
        btn_hist[1].push_front(btn_next_raw);
        void'(btn_hist[1].pop_back());

        exp_valid = acc_prev[0];
        exp_next = acc_prev[1] && !acc_prev[0];
        if (acc_prev[0]) exp_sample = sw_hist[2];

        for (int i = 0; i < 2; i++) begin
            acc[i] = 1'b0;
            b = btn_hist[i][2];
            if (!m_pressed[i]) begin
                m_run[i] = b ? m_run[i] + 1 : 0;
                if (m_run[i] == int'(D) + 1) begin
                    m_pressed[i] = 1'b1;
                    m_run[i] = 0;
                    m_age[i] = 0;
                    acc[i] = 1'b1;
                end
            end else begin
                m_run[i] = b ? 0 : m_run[i] + 1;
                if (m_run[i] == int'(D) + 1) begin
                    m_pressed[i] = 1'b0;
                    m_run[i] = 0;
                end
                if (m_run[i] > 0 || !m_pressed[i]) begin
                    m_age[i] = -1;
                end else if (m_age[i] >= 0) begin
                    m_age[i]++;
`ifdef CAPTURE_AUTOREPEAT_EN
                    if (i == 1 && (m_age[i] % int'(R)) == 0) acc[i] = 1'b1;
`endif
                end
            end
        end
        acc_prev = acc;
    endtask

    task automatic mark();
        base = cyc;
        n_valid = 0;
        n_next = 0;
        first_valid = -1;
        first_next = -1;
        next_idx.delete();
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("valid", 32'(sample_in_valid), 32'(exp_valid));
        check("next", 32'(next_sample), 32'(exp_next));
        check("sample", 32'(sample_in), 32'(exp_sample));
        if (sample_in_valid === 1'b1) begin
            if (n_valid == 0) first_valid = cyc - base;
            n_valid++;
        end
        if (next_sample === 1'b1) begin
            if (n_next == 0) first_next = cyc - base;
            next_idx.push_back(cyc - base);
            n_next++;
        end
        cyc++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int seg_left[2];
        bit level[2];

        model_reset();
        mark();

        // Reset then idle
        reset = 1'b1;
        ticks(3);
        reset = 1'b0;
        mark();
        ticks(20);
        check("idle_valid_count", 32'(n_valid), 32'd0);
        check("idle_next_count", 32'(n_next), 32'd0);
        check("idle_sample", 32'(sample_in), 32'h00);

        // Clean store press
        sw_raw = 8'hA5;
        btn_store_raw = 1'b1;
        mark();
        ticks(10);
        check("store_latency", 32'(first_valid), 32'd7);
        check("store_count", 32'(n_valid), 32'd1);
        check("store_value", 32'(sample_in), 32'hA5);
        sw_raw = 8'h3C;
        ticks(5);
        check("store_hold", 32'(sample_in), 32'hA5);
        btn_store_raw = 1'b0;
        ticks(8);

        // Press bounce, then steady high, then release bounce
        mark();
        for (int i = 0; i < 10; i++) begin
            btn_store_raw = (i % 2 == 0);
            tick();
        end
        check("bounce_no_strobe", 32'(n_valid), 32'd0);
        btn_store_raw = 1'b1;
        mark();
        ticks(12);
        check("bounce_latency", 32'(first_valid), 32'd7);
        check("bounce_count", 32'(n_valid), 32'd1);
        check("bounce_value", 32'(sample_in), 32'h3C);
        mark();
        for (int i = 0; i < 6; i++) begin
            btn_store_raw = (i % 2 == 1);
            tick();
        end
        btn_store_raw = 1'b0;
        ticks(10);
        check("release_bounce", 32'(n_valid), 32'd0);

        // Simultaneous store and next
        sw_raw = 8'h5A;
        btn_store_raw = 1'b1;
        btn_next_raw = 1'b1;
        mark();
        ticks(12);
        check("collide_valid_at", 32'(first_valid), 32'd7);
        check("collide_valid_count", 32'(n_valid), 32'd1);
        check("collide_value", 32'(sample_in), 32'h5A);
        btn_store_raw = 1'b0;
        btn_next_raw = 1'b0;
        ticks(10);
        check("collide_next_count", 32'(n_next), 32'd0);

        // Next held for 40 cycles
        btn_next_raw = 1'b1;
        mark();
        ticks(40);
`ifdef CAPTURE_AUTOREPEAT_EN
        check("repeat_count", 32'(n_next), 32'd4);
        for (int k = 0; k < 4 && k < next_idx.size(); k++) begin
            check("repeat_edge", 32'(next_idx[k]), 32'(7 + 10 * k));
        end
`else
        check("next_count", 32'(n_next), 32'd1);
        check("next_latency", 32'(first_next), 32'd7);
`endif
        btn_next_raw = 1'b0;
        ticks(10);

        // Reset during press qualification with the button held through it
        sw_raw = 8'hC3;
        btn_store_raw = 1'b1;
        mark();
        ticks(4);
        reset = 1'b1;
        ticks(3);
        check("reset_abort", 32'(n_valid), 32'd0);
        check("reset_sample", 32'(sample_in), 32'h00);
        reset = 1'b0;
        mark();
        ticks(12);
        check("post_reset_latency", 32'(first_valid), 32'd7);
        check("post_reset_count", 32'(n_valid), 32'd1);
        check("post_reset_value", 32'(sample_in), 32'hC3);
        btn_store_raw = 1'b0;
        ticks(10);

        // Randomised bouncing on both buttons against the model
        seg_left = '{0, 0};
        level = '{1'b0, 1'b0};
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (seg_left[i] == 0) begin
                    level[i] = ~level[i];
                    seg_left[i] = int'($urandom_range(1, 8));
                end
                seg_left[i]--;
            end
            btn_store_raw = level[0];
            btn_next_raw = level[1];
            sw_raw = 8'($urandom);
            tick();
        end
        btn_store_raw = 1'b0;
        btn_next_raw = 1'b0;
        ticks(12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
